// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-to-ALU command bridge.
// Holds the FSM state encoding, default widths and the ALU opcode map.
package uart_alu_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int OP_W_DEF    = 6;
    localparam int TIMEOUT_DEF = 104166;

    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        POP_A   = 3'd1,
        WAIT_B  = 3'd2,
        POP_B   = 3'd3,
        WAIT_OP = 3'd4,
        POP_OP  = 3'd5,
        EXEC    = 3'd6,
        SEND    = 3'd7
    } state_t;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_SUB = 6'h22;
    localparam logic [5:0] OP_AND = 6'h24;
    localparam logic [5:0] OP_OR  = 6'h25;
    localparam logic [5:0] OP_XOR = 6'h26;
    localparam logic [5:0] OP_NOR = 6'h27;
    localparam logic [5:0] OP_SRA = 6'h03;
    localparam logic [5:0] OP_SRL = 6'h02;

    // States in which the inter-byte timeout is armed.
    function automatic logic in_gap(state_t s);
        return (s == WAIT_B) || (s == WAIT_OP);
    endfunction

endpackage

// File: rtl/uart_alu_interface_frame_timer.sv
// Clearable up-counter that saturates at TERMINAL-1; expired is combinational
// while enabled at the terminal count. No backpressure.
module frame_timer #(
    parameter int TERMINAL = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/uart_alu_interface.sv
// Collects A, B, opcode bytes from the UART RX FIFO, runs the external ALU and pushes
// the result; wr_uart follows the opcode pop by 2 cycles, SEND stalls indefinitely on tx_full.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int OP_W           = OP_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [DATA_W-1:0] r_data,
    input  logic              tx_full,
    input  logic [DATA_W-1:0] alu_result,
    output logic              rd_uart,
    output logic              wr_uart,
    output logic [DATA_W-1:0] w_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              busy,
    output logic              frame_err
);

    state_t state;
    logic   expired;

    frame_timer #(
        .TERMINAL (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == POP_A) || (state == POP_B)),
        .en      (in_gap(state)),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= WAIT_A;
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            w_data    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rd_uart   <= 1'b0;
            wr_uart   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                WAIT_A: begin
                    if (!rx_empty) begin
                        alu_a   <= r_data;
                        rd_uart <= 1'b1;
                        busy    <= 1'b1;
                        state   <= POP_A;
                    end
                end
                POP_A: state <= WAIT_B;
                WAIT_B: begin
                    // A byte arriving in the expiring cycle wins over the timeout.
                    if (!rx_empty) begin
                        alu_b   <= r_data;
                        rd_uart <= 1'b1;
                        state   <= POP_B;
                    end else if (expired) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= WAIT_A;
                    end
                end
                POP_B: state <= WAIT_OP;
                WAIT_OP: begin
                    if (!rx_empty) begin
                        alu_op  <= r_data[OP_W-1:0];
                        rd_uart <= 1'b1;
                        state   <= POP_OP;
                    end else if (expired) begin
                        frame_err <= 1'b1;
                        busy      <= 1'b0;
                        state     <= WAIT_A;
                    end
                end
                POP_OP: state <= EXEC;
                EXEC: begin
                    // tx_full sampled here lets the push land in the first SEND cycle.
                    w_data  <= alu_result;
                    wr_uart <= !tx_full;
                    state   <= SEND;
                end
                SEND: begin
                    if (wr_uart) begin
                        busy  <= 1'b0;
                        state <= WAIT_A;
                    end else if (!tx_full) begin
                        wr_uart <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= WAIT_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: RX FIFO model, behavioural ALU, result scoreboard.
module tb_uart_alu_interface;
    import uart_alu_pkg::*;

    localparam int TO = 16;

    logic       clk;
    logic       reset;
    logic       rx_empty;
    logic [7:0] r_data;
    logic       tx_full;
    logic [7:0] alu_result;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] w_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic       busy;
    logic       frame_err;

    uart_alu_interface #(
        .DATA_W         (8),
        .OP_W           (6),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_empty   (rx_empty),
        .r_data     (r_data),
        .tx_full    (tx_full),
        .alu_result (alu_result),
        .rd_uart    (rd_uart),
        .wr_uart    (wr_uart),
        .w_data     (w_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [5:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRA:  return $signed(a) >>> b[2:0];
            OP_SRL:  return a >> b[2:0];
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_op);

    // First-word-fall-through RX FIFO model
    logic [7:0] rx_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rx_empty = (rd_ptr == wr_ptr);
    assign r_data   = rx_mem[rd_ptr % 256];
    always @(posedge clk) if (rd_uart === 1'b1) rd_ptr <= rd_ptr + 1;

    // Event monitor
    int   cyc = 0, n_pops = 0, n_push = 0, n_ferr = 0, b2b = 0;
    int   last_pop = 0, last_push = 0, last_ferr = 0;
    logic prev_rd = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rd_uart === 1'b1) begin
            n_pops++;
            last_pop = cyc;
            if (prev_rd) b2b++;
        end
        prev_rd = (rd_uart === 1'b1);
        if (wr_uart === 1'b1) begin
            n_push++;
            last_push = cyc;
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            last_ferr = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_mem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input logic [7:0] exp);
        push_byte(a);
        push_byte(b);
        push_byte(op);
        exp_q.push_back(exp);
    endtask

    task automatic wait_pops(input string tag, input int target);
        int n;
        n = 0;
        while (n_pops < target && n < 80) begin
            tick();
            n++;
        end
        check(tag, (n_pops >= target), 1);
    endtask

    task automatic expect_push(input string tag, input bit chk_lat);
        int n;
        logic [7:0] e;
        n = 0;
        while (wr_uart !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        check({tag, "_seen"}, wr_uart, 1);
        if (wr_uart === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_data"}, w_data, e);
            if (chk_lat) check({tag, "_lat"}, last_push - last_pop, 2);
        end
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, q0, f0, b0, pa, busy_lo;
        reset   = 1'b0;
        tx_full = 1'b0;
        repeat (3) tick();
        check("rst_ctl", {rd_uart, wr_uart, busy, frame_err}, 0);
        check("rst_regs", {w_data, alu_a, alu_b, alu_op}, 0);
        reset = 1'b1;
        tick();

        // 1: single frame, latency and operand outputs
        p0 = n_pops; q0 = n_push;
        send_frame(8'h0A, 8'h05, 8'h20, 8'h0F);
        expect_push("t1", 1'b1);
        check("t1_ops", {alu_a, alu_b, alu_op}, {8'h0A, 8'h05, 6'h20});
        check("t1_busy", busy, 0);
        repeat (3) tick();
        check("t1_pops", n_pops - p0, 3);
        check("t1_pushes", n_push - q0, 1);

        // 2: back-to-back frames
        p0 = n_pops; b0 = b2b;
        send_frame(8'h0F, 8'h03, 8'h22, 8'h0C);
        send_frame(8'hF0, 8'h0F, 8'h25, 8'hFF);
        expect_push("t2a", 1'b1);
        expect_push("t2b", 1'b1);
        repeat (2) tick();
        check("t2_pops", n_pops - p0, 6);
        check("t2_b2b", b2b - b0, 0);

        // 3: stall in SEND on tx_full
        tx_full = 1'b1;
        p0 = n_pops; q0 = n_push; busy_lo = 0;
        send_frame(8'h3C, 8'h0F, 8'h26, 8'h33);
        wait_pops("t3_reach", p0 + 3);
        repeat (2) tick();
        repeat (20) begin
            if (busy !== 1'b1) busy_lo++;
            tick();
        end
        check("t3_no_push", n_push - q0, 0);
        check("t3_busy", busy_lo, 0);
        check("t3_no_pop", n_pops - p0, 3);
        tx_full = 1'b0;
        expect_push("t3", 1'b0);
        repeat (2) tick();
        check("t3_one_push", n_push - q0, 1);

        // 4: timeout after operand A
        p0 = n_pops; f0 = n_ferr;
        push_byte(8'h11);
        wait_pops("t4_popa", p0 + 1);
        pa = last_pop;
        begin
            int n;
            n = 0;
            while (n_ferr == f0 && n < 40) begin
                tick();
                n++;
            end
        end
        check("t4_ferr_seen", n_ferr - f0, 1);
        check("t4_ferr_time", last_ferr - pa, TO + 1);
        tick();
        check("t4_ferr_pulse", frame_err, 0);
        check("t4_idle", busy, 0);
        check("t4_a_kept", alu_a, 8'h11);
        send_frame(8'h01, 8'h02, 8'h20, 8'h03);
        expect_push("t4", 1'b1);

        // 5: byte arrives in the expiring cycle
        p0 = n_pops; f0 = n_ferr;
        push_byte(8'h21);
        wait_pops("t5_popa", p0 + 1);
        pa = last_pop;
        repeat (TO) tick();
        push_byte(8'h06);
        push_byte(8'h22);
        exp_q.push_back(8'h1B);
        wait_pops("t5_popb", p0 + 2);
        check("t5_popb_time", last_pop - pa, TO + 1);
        expect_push("t5", 1'b1);
        check("t5_no_ferr", n_ferr - f0, 0);

        // 6: asynchronous reset mid-frame
        p0 = n_pops;
        push_byte(8'h55);
        push_byte(8'h66);
        wait_pops("t6_two", p0 + 2);
        tick();
        check("t6_busy_pre", busy, 1);
        reset = 1'b0;
        #1;
        check("t6_rst_ctl", {rd_uart, wr_uart, busy, frame_err}, 0);
        check("t6_rst_regs", {w_data, alu_a, alu_b, alu_op}, 0);
        tick();
        reset = 1'b1;
        tick();
        send_frame(8'h07, 8'h03, 8'h24, 8'h03);
        expect_push("t6", 1'b1);
        check("sb_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
